// File: rtl/sfifo_flex.sv
// sfifo_flex: single-clock FIFO with flip-flop storage, any depth >= 2,
// standard or first-word-fall-through read, level output with programmable
// almost-full / almost-empty thresholds, synchronous flush and sticky
// overflow / underflow flags.
//
// Full and empty are decoded only from the level register. The pointers wrap
// at DEPTH-1, so no extra pointer bit is needed to tell full from empty.
module sfifo_flex #(
    parameter int DW     = 16,
    parameter int DEPTH  = 11,
    parameter int FWFT   = 0,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          fifo_we,
    input  logic [DW-1:0] fifo_wd,
    input  logic          fifo_re,
    input  logic          fifo_fsh,
    output logic [DW-1:0] fifo_rd,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          fifo_afull,
    output logic          fifo_aempty,
    output logic [LW-1:0] fifo_lvl,
    output logic          fifo_ovf,
    output logic          fifo_udf
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_lvl;
    logic          r_ovf;
    logic          r_udf;

    logic          w_full;
    logic          w_empty;
    logic          w_rd_acc;
    logic          w_wr_acc;
    logic          w_ovf_set;
    logic          w_udf_set;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;

    assign w_full     = (r_lvl == LW'(DEPTH));
    assign w_empty    = (r_lvl == '0);

    // A read frees a slot in the same cycle, so a full FIFO still accepts a
    // write when it is paired with an accepted read.
    assign w_rd_acc   = fifo_re & ~fifo_fsh & ~w_empty;
    assign w_wr_acc   = fifo_we & ~fifo_fsh & (~w_full | w_rd_acc);
    assign w_ovf_set  = fifo_we & w_full & ~w_rd_acc & ~fifo_fsh;
    assign w_udf_set  = fifo_re & w_empty & ~fifo_fsh;

    assign w_wptr_nxt = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
    assign w_rptr_nxt = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);

    // Pointers, level and sticky error flags; flush returns them to reset values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_lvl  <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else if (fifo_fsh) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_lvl  <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            if (w_wr_acc) r_wptr <= w_wptr_nxt;
            if (w_rd_acc) r_rptr <= w_rptr_nxt;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_lvl <= r_lvl + LW'(1);
                2'b01:   r_lvl <= r_lvl - LW'(1);
                default: r_lvl <= r_lvl;
            endcase
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_udf_set) r_udf <= 1'b1;
        end
    end

    // Storage is not reset; the level register alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wptr] <= fifo_wd;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign fifo_rd = r_mem[r_rptr];
        end else begin : g_std
            logic [DW-1:0] r_rd;

            // Registered read data, loaded only by an accepted read.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)         r_rd <= '0;
                else if (w_rd_acc) r_rd <= r_mem[r_rptr];
            end

            assign fifo_rd = r_rd;
        end
    endgenerate

    assign fifo_full   = w_full;
    assign fifo_empty  = w_empty;
    assign fifo_afull  = (r_lvl >= LW'(AF_LVL));
    assign fifo_aempty = (r_lvl <= LW'(AE_LVL));
    assign fifo_lvl    = r_lvl;
    assign fifo_ovf    = r_ovf;
    assign fifo_udf    = r_udf;

endmodule
